rps_classify_sequencer: RTL and testbench

//  Multi-cycle sequencer for rock/paper/scissors classification of binary hand images.

---
 rtl/rps_pkg.sv | 32 +++
 rtl/rps_row_features.sv | 40 ++++
 rtl/rps_classify_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rps_classify_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// Shared types and sizing helpers for the rock/paper/scissors classification sequencer.
package rps_pkg;

    typedef enum logic [1:0] {
        ROCK     = 2'd0,
        PAPER    = 2'd1,
        SCISSORS = 2'd2
    } rps_class_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } seq_state_e;

    // Bits needed to hold any count from 0 to max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // Bits needed to index n entries (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Left-band pixel count above which an open hand (PAPER) is declared.
    function automatic int thresh(input int length, input int width);
        return length * width / 50;
    endfunction

endpackage

// File: rtl/rps_row_features.sv
// Combinational per-row features: left-band popcount and lowest set column index.
// With RPS_FEATURE_OUT_EN defined it also provides the full-row popcount.
module rps_row_features
    import rps_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int LEFT  = 8,
    localparam int PW    = cnt_w(WIDTH),
    localparam int LW    = cnt_w(LEFT)
) (
    input  logic [WIDTH-1:0] row,
`ifdef RPS_FEATURE_OUT_EN
    output logic [PW-1:0]    pop,
`endif
    output logic [LW-1:0]    pop_left,
    output logic [PW-1:0]    low_idx
);

`ifdef RPS_FEATURE_OUT_EN
    always_comb begin
        pop = '0;
        for (int j = 0; j < WIDTH; j++) pop = pop + PW'(row[j]);
    end
`endif

    // NOTE: every output is given a default before the loops so no latch can be inferred.
    always_comb begin
        pop_left = '0;
        for (int j = 0; j < LEFT; j++) pop_left = pop_left + LW'(row[j]);
    end

    // Scanning from the top down lets the lowest set column overwrite the rest; WIDTH means empty row.
    always_comb begin
        low_idx = PW'(WIDTH);
        for (int j = WIDTH - 1; j >= 0; j--) begin
            if (row[j]) low_idx = PW'(j);
        end
    end

endmodule

// File: rtl/rps_classify_sequencer.sv
// Buffers a binary hand image row by row, scans a probe column, and reports a 2-bit gesture class.
// Defining RPS_FEATURE_OUT_EN adds registered feature outputs valid alongside result_valid.
module rps_classify_sequencer
    import rps_pkg::*;
#(
    parameter  int LENGTH = 32,
    parameter  int WIDTH  = 32,
    parameter  int LEFT   = 8,
    parameter  int SHIFT  = 4,
    localparam int SUM_W  = cnt_w(LENGTH * WIDTH),
    localparam int SL_W   = cnt_w(LENGTH * LEFT),
    localparam int LM_W   = cnt_w(WIDTH),
    localparam int TR_W   = idx_w(LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             row_valid,
    output logic             row_ready,
    input  logic [WIDTH-1:0] row_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       result,
`ifdef RPS_FEATURE_OUT_EN
    output logic [SUM_W-1:0] feat_sum,
    output logic [SL_W-1:0]  feat_sum_left,
    output logic [LM_W-1:0]  feat_leftmost,
    output logic [TR_W-1:0]  feat_trans,
`endif
    output logic             busy
);

    localparam int RI_W  = idx_w(LENGTH);
    localparam int CI_W  = idx_w(WIDTH);
    localparam int COL_W = LM_W + 1;
    localparam int PL_W  = cnt_w(LEFT);
    localparam logic [RI_W-1:0] LAST_ROW = RI_W'(LENGTH - 1);
    localparam logic [SL_W-1:0] THRESH_V = SL_W'(thresh(LENGTH, WIDTH));

    seq_state_e       state, state_nxt;
    logic [RI_W-1:0]  row_cnt, scan_cnt, scan_nxt;
    logic [WIDTH-1:0] frame [LENGTH];
    logic [SL_W-1:0]  sum_left;
    logic [LM_W-1:0]  leftmost, low_idx;
    logic [TR_W-1:0]  trans;
    logic [PL_W-1:0]  pop_left;
    logic [COL_W-1:0] col;
    logic [CI_W-1:0]  col_idx;
    logic [WIDTH-1:0] cur_row, nxt_row;
    logic             row_fire, col_ok, probe_diff, scan_last, clear;
    rps_class_e       class_nxt, class_q;

`ifdef RPS_FEATURE_OUT_EN
    logic [SUM_W-1:0] sum;
    logic [LM_W-1:0]  pop;
`endif

    rps_row_features #(.WIDTH(WIDTH), .LEFT(LEFT)) u_row_features (
        .row      (row_data),
`ifdef RPS_FEATURE_OUT_EN
        .pop      (pop),
`endif
        .pop_left (pop_left),
        .low_idx  (low_idx)
    );

    // NOTE: reset is synchronous and active-high to match the surrounding codebase.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        row_ready    = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                row_ready = 1'b1;
                busy      = 1'b0;
                if (row_valid) state_nxt = LOAD;
            end
            LOAD: begin
                row_ready = 1'b1;
                if (row_valid && row_cnt == LAST_ROW) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_cnt == LAST_ROW) state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_nxt = IDLE;
            end
        endcase
    end

    assign row_fire  = row_valid && row_ready;
    assign scan_last = (state == SCAN) && (scan_cnt == LAST_ROW);
    assign clear     = rst || (state == DONE && result_ready);

    // Probe column; one bit wider than leftmost so leftmost+SHIFT can never wrap into range.
    assign col        = COL_W'(leftmost) + COL_W'(SHIFT);
    assign col_idx    = col[CI_W-1:0];
    assign col_ok     = (leftmost != LM_W'(WIDTH)) && (col < COL_W'(WIDTH));
    assign scan_nxt   = scan_cnt + RI_W'(1);
    assign cur_row    = frame[scan_cnt];
    assign nxt_row    = frame[scan_nxt];
    assign probe_diff = col_ok && (scan_cnt != LAST_ROW) && (cur_row[col_idx] != nxt_row[col_idx]);

    // NOTE: the frame buffer has no reset; every entry is rewritten during LOAD before SCAN reads it.
    always_ff @(posedge clk) begin
        if (row_fire) frame[row_cnt] <= row_data;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            row_cnt  <= '0;
            scan_cnt <= '0;
            sum_left <= '0;
            leftmost <= LM_W'(WIDTH);
            trans    <= '0;
`ifdef RPS_FEATURE_OUT_EN
            sum      <= '0;
`endif
        end else begin
            if (row_fire) begin
                row_cnt  <= row_cnt + RI_W'(1);
                sum_left <= sum_left + SL_W'(pop_left);
                if (low_idx < leftmost) leftmost <= low_idx;
`ifdef RPS_FEATURE_OUT_EN
                sum      <= sum + SUM_W'(pop);
`endif
            end
            // The final SCAN cycle makes no comparison; it lets trans settle before the class is latched.
            if (state == SCAN) begin
                scan_cnt <= scan_nxt;
                if (probe_diff) trans <= trans + TR_W'(1);
            end
        end
    end

    always_comb begin
        class_nxt = ROCK;
        if (trans == TR_W'(4))       class_nxt = SCISSORS;
        else if (sum_left > THRESH_V) class_nxt = PAPER;
    end

    always_ff @(posedge clk) begin
        if (rst)            class_q <= ROCK;
        else if (scan_last) class_q <= class_nxt;
    end

    assign result = class_q;

`ifdef RPS_FEATURE_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_sum      <= '0;
            feat_sum_left <= '0;
            feat_leftmost <= '0;
            feat_trans    <= '0;
        end else if (scan_last) begin
            feat_sum      <= sum;
            feat_sum_left <= sum_left;
            feat_leftmost <= leftmost;
            feat_trans    <= trans;
        end
    end
`endif

endmodule

// File: tb/tb_rps_classify_sequencer.sv
// Scoreboard bench for rps_classify_sequencer: random and directed frames against an image-level model.
// Feature outputs are also checked when RPS_FEATURE_OUT_EN is defined.
module tb_rps_classify_sequencer;
    import rps_pkg::*;

    localparam int LENGTH = 32;
    localparam int WIDTH  = 32;
    localparam int LEFT   = 8;
    localparam int SHIFT  = 4;
    localparam int THRESH = LENGTH * WIDTH / 50;

    typedef struct {
        int     cls;
        int     sum;
        int     sum_left;
        int     leftmost;
        int     trans;
        longint accept_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             row_valid;
    logic             row_ready;
    logic [WIDTH-1:0] row_data;
    logic             result_valid;
    logic             result_ready;
    logic [1:0]       result;
    logic             busy;
`ifdef RPS_FEATURE_OUT_EN
    logic [10:0]      feat_sum;
    logic [8:0]       feat_sum_left;
    logic [5:0]       feat_leftmost;
    logic [4:0]       feat_trans;
`endif

    rps_classify_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_data     (row_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
`ifdef RPS_FEATURE_OUT_EN
        .feat_sum      (feat_sum),
        .feat_sum_left (feat_sum_left),
        .feat_leftmost (feat_leftmost),
        .feat_trans    (feat_trans),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] img [LENGTH];
    exp_t   sb[$];
    longint cyc = 0;
    longint last_accept = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     rr_mode = 1;   // 0 hold low, 1 hold high, 2 random
    bit     gaps = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model evaluated directly on the stored image.
    function automatic exp_t model();
        exp_t e;
        int   col;
        e.sum = 0; e.sum_left = 0; e.leftmost = WIDTH; e.trans = 0; e.accept_cyc = 0;
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < WIDTH; c++)
                if (img[r][c]) begin
                    e.sum++;
                    if (c < LEFT) e.sum_left++;
                    if (c < e.leftmost) e.leftmost = c;
                end
        col = e.leftmost + SHIFT;
        if (col < WIDTH)
            for (int r = 0; r < LENGTH - 1; r++)
                if (img[r][col] != img[r+1][col]) e.trans++;
        e.cls = (e.trans == 4) ? 2 : (e.sum_left > THRESH) ? 1 : 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rr_mode == 2) result_ready = 1'($urandom_range(1));
        else              result_ready = (rr_mode == 1);
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        bit   seen = 0;
        bit   post_hs = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                post_hs = 0;
            end else begin
                if (post_hs) begin
                    check("row_ready_after_handshake", row_ready, 1);
                    check("busy_after_handshake", busy, 0);
                    post_hs = 0;
                end
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result_valid", sb.size(), 1);
                    end else begin
                        e = sb[0];
                        if (!seen) begin
                            check("result_latency", cyc - e.accept_cyc, LENGTH);
                            seen = 1;
                        end
                        check("result_class", result, e.cls);
                        check("row_ready_while_done", row_ready, 0);
                        check("busy_while_done", busy, 1);
`ifdef RPS_FEATURE_OUT_EN
                        check("feat_sum", feat_sum, e.sum);
                        check("feat_sum_left", feat_sum_left, e.sum_left);
                        check("feat_leftmost", feat_leftmost, e.leftmost);
                        check("feat_trans", feat_trans, e.trans);
`endif
                        if (result_ready) begin
                            void'(sb.pop_front());
                            seen = 0;
                            post_hs = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        row_valid = 1'b0;
        repeat (2) tick();
        check("reset_row_ready", row_ready, 1);
        check("reset_result_valid", result_valid, 0);
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
    endtask

    task automatic send_rows(input int n_rows, output bit ok);
        ok = 1;
        for (int r = 0; r < n_rows; r++) begin
            int waited = 0;
            bit acc = 0;
            if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) tick();
            row_valid = 1'b1;
            row_data  = img[r];
            while (!acc) begin
                @(negedge clk);
                acc = row_ready;
                tick();
                if (!acc && ++waited > 200) begin
                    check("row_ready_wait", acc, 1);
                    ok = 0;
                    row_valid = 1'b0;
                    return;
                end
            end
            last_accept = cyc;
            row_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        if (sb.size() != 0) begin
            check("result_timeout", sb.size(), 0);
            sb.delete();
            do_reset();
        end
    endtask

    task automatic issue_frame();
        bit   ok;
        exp_t e;
        send_rows(LENGTH, ok);
        if (ok) begin
            e = model();
            e.accept_cyc = last_accept;
            sb.push_back(e);
        end
    endtask

    task automatic run_frame();
        issue_frame();
        drain();
    endtask

    task automatic clear_img();
        for (int r = 0; r < LENGTH; r++) img[r] = '0;
    endtask

    task automatic img_scissors();
        clear_img();
        img[0][10] = 1'b1;
        for (int r = 4; r < 8; r++)   img[r][14] = 1'b1;
        for (int r = 12; r < 16; r++) img[r][14] = 1'b1;
    endtask

    task automatic img_random(input int style);
        int l, b;
        clear_img();
        case (style)
            0: for (int r = 0; r < LENGTH; r++) img[r] = $urandom & $urandom & $urandom & $urandom;
            1: begin
                l = $urandom_range(0, WIDTH - 1);
                img[0][l] = 1'b1;
                b = 0;
                if (l + SHIFT < WIDTH)
                    for (int r = 0; r < LENGTH; r++) begin
                        if ($urandom_range(5) == 0) b = !b;
                        img[r][l+SHIFT] = 1'(b);
                    end
            end
            2: for (int k = 0; k < $urandom_range(14, 27); k++) img[k/LEFT][k%LEFT] = 1'b1;
            default: for (int r = 0; r < LENGTH; r++) img[r] = $urandom;
        endcase
    endtask

    initial begin
        bit ok;
        int w;
        rst = 1'b1;
        row_valid = 1'b0;
        row_data = '0;
        result_ready = 1'b1;
        do_reset();

        // All-zero image: ROCK, empty-image sentinel.
        clear_img();
        run_frame();

        // Probe column with four transitions: SCISSORS.
        img_scissors();
        run_frame();

        // Full left band in three rows: PAPER.
        clear_img();
        for (int r = 0; r < 3; r++) img[r][7:0] = 8'hFF;
        run_frame();

        // Exactly THRESH left-band pixels stays ROCK.
        clear_img();
        for (int r = 0; r < 10; r++) img[r][1:0] = 2'b11;
        run_frame();

        // Probe column falls outside the image.
        clear_img();
        for (int r = 0; r < LENGTH; r += 3) img[r][30] = 1'b1;
        run_frame();

        // Back-pressure: result held, rows refused, then release.
        rr_mode = 0;
        clear_img();
        for (int r = 0; r < 3; r++) img[r][7:0] = 8'hFF;
        issue_frame();
        w = 0;
        while (!result_valid && w < 100) begin
            tick();
            w++;
        end
        check("stall_result_valid", result_valid, 1);
        row_valid = 1'b1;
        row_data  = '1;
        repeat (10) tick();
        row_valid = 1'b0;
        rr_mode = 1;
        drain();

        // Partial frame discarded by reset, then the same image classifies as usual.
        img_scissors();
        send_rows(16, ok);
        do_reset();
        run_frame();

        // Randomized frames with input gaps and random back-pressure.
        gaps = 1;
        rr_mode = 2;
        for (int i = 0; i < 24; i++) begin
            img_random(i % 4);
            run_frame();
        end
        rr_mode = 1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
